// File: rtl/unified_mem_arbiter_pkg.sv
// rtl/unified_mem_arbiter_pkg.sv - shared types and constants for the unified memory arbiter
package unified_mem_arbiter_pkg;

    typedef enum logic {
        ST_BOOT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_DM   = 2'd2
    } owner_t;

    localparam logic [3:0] BE_ALL = 4'hF;

endpackage

// File: rtl/unified_mem_arbiter.sv
// rtl/unified_mem_arbiter.sv - boot sequencer and fetch/data arbiter in front of one single-port SRAM
module unified_mem_arbiter
    import unified_mem_arbiter_pkg::*;
#(
    parameter int MEM_AW     = 6,
    parameter int STARVE_MAX = 3
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              if_req_in,
    input  logic [31:0]       if_addr_in,
    output logic              if_gnt_out,
    output logic              if_rvalid_out,
    output logic [31:0]       if_rdata_out,
    input  logic              dm_req_in,
    input  logic              dm_we_in,
    input  logic [3:0]        dm_be_in,
    input  logic [31:0]       dm_addr_in,
    input  logic [31:0]       dm_wdata_in,
    output logic              dm_gnt_out,
    output logic              dm_rvalid_out,
    output logic [31:0]       dm_rdata_out,
    output logic              dm_err_out,
    input  logic              ld_req_in,
    input  logic [31:0]       ld_addr_in,
    input  logic [31:0]       ld_wdata_in,
    input  logic              ld_done_in,
    output logic              ld_gnt_out,
    output logic              core_stall_out,
    output logic              mem_en_out,
    output logic              mem_we_out,
    output logic [3:0]        mem_be_out,
    output logic [MEM_AW-1:0] mem_addr_out,
    output logic [31:0]       mem_wdata_out,
    input  logic [31:0]       mem_rdata_in
);

    localparam int CW = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

    state_t        state;
    owner_t        owner;
    logic [CW-1:0] starve_cnt;
    logic          rsp_oor;
    logic          if_oor;
    logic          dm_oor;
    logic          fetch_first;

    assign if_oor      = |if_addr_in[31:MEM_AW+2];
    assign dm_oor      = |dm_addr_in[31:MEM_AW+2];
    assign fetch_first = (starve_cnt == STARVE_LIM);

    // Byte offsets and loader high bits carry no meaning for a word-wide SRAM.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{if_addr_in[1:0], dm_addr_in[1:0], ld_addr_in[1:0],
                                ld_addr_in[31:MEM_AW+2]};

    always_comb begin
        if_gnt_out     = 1'b0;
        dm_gnt_out     = 1'b0;
        ld_gnt_out     = 1'b0;
        core_stall_out = 1'b1;
        mem_en_out     = 1'b0;
        mem_we_out     = 1'b0;
        mem_be_out     = 4'h0;
        mem_addr_out   = '0;
        mem_wdata_out  = '0;
        if (!rst_in) begin
            if (state == ST_BOOT) begin
                ld_gnt_out = ld_req_in;
                if (ld_req_in) begin
                    mem_en_out    = 1'b1;
                    mem_we_out    = 1'b1;
                    mem_be_out    = BE_ALL;
                    mem_addr_out  = ld_addr_in[MEM_AW+1:2];
                    mem_wdata_out = ld_wdata_in;
                end
            end else begin
                if_gnt_out     = if_req_in & (~dm_req_in | fetch_first);
                dm_gnt_out     = dm_req_in & ~if_gnt_out;
                core_stall_out = (if_req_in & ~if_gnt_out) | (dm_req_in & ~dm_gnt_out);
                // Out-of-range accesses are still granted so the core moves on; the SRAM is left idle.
                if (if_gnt_out) begin
                    mem_en_out   = ~if_oor;
                    mem_addr_out = if_addr_in[MEM_AW+1:2];
                end else if (dm_gnt_out) begin
                    mem_en_out    = ~dm_oor;
                    mem_we_out    = dm_we_in & ~dm_oor;
                    mem_be_out    = dm_we_in ? dm_be_in : 4'h0;
                    mem_addr_out  = dm_addr_in[MEM_AW+1:2];
                    mem_wdata_out = dm_wdata_in;
                end
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state      <= ST_BOOT;
            owner      <= OWN_NONE;
            starve_cnt <= '0;
            rsp_oor    <= 1'b0;
            dm_err_out <= 1'b0;
        end else begin
            if (state == ST_BOOT && ld_done_in) begin
                state <= ST_RUN;
            end
            if (state == ST_RUN && if_req_in && !if_gnt_out) begin
                starve_cnt <= fetch_first ? starve_cnt : starve_cnt + 1'b1;
            end else begin
                starve_cnt <= '0;
            end
            if (if_gnt_out) begin
                owner <= OWN_IF;
            end else if (dm_gnt_out && !dm_we_in) begin
                owner <= OWN_DM;
            end else begin
                owner <= OWN_NONE;
            end
            rsp_oor    <= if_gnt_out ? if_oor : dm_oor;
            dm_err_out <= dm_gnt_out & dm_oor;
        end
    end

    assign if_rvalid_out = (owner == OWN_IF);
    assign dm_rvalid_out = (owner == OWN_DM);
    assign if_rdata_out  = (if_rvalid_out && !rsp_oor) ? mem_rdata_in : 32'h0;
    assign dm_rdata_out  = (dm_rvalid_out && !rsp_oor) ? mem_rdata_in : 32'h0;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// tb/tb_unified_mem_arbiter.sv - directed and randomized checks of unified_mem_arbiter against a reference model
module tb_unified_mem_arbiter;

    localparam int AW = 6;
    localparam int SM = 3;

    logic          clk_in = 1'b0;
    logic          rst_in;
    logic          if_req_in, if_gnt_out, if_rvalid_out;
    logic [31:0]   if_addr_in, if_rdata_out;
    logic          dm_req_in, dm_we_in, dm_gnt_out, dm_rvalid_out, dm_err_out;
    logic [3:0]    dm_be_in;
    logic [31:0]   dm_addr_in, dm_wdata_in, dm_rdata_out;
    logic          ld_req_in, ld_done_in, ld_gnt_out;
    logic [31:0]   ld_addr_in, ld_wdata_in;
    logic          core_stall_out, mem_en_out, mem_we_out;
    logic [3:0]    mem_be_out;
    logic [AW-1:0] mem_addr_out;
    logic [31:0]   mem_wdata_out, mem_rdata_in;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] sram    [0:63];
    logic [31:0] ref_mem [0:63];

    bit          m_run;
    int          denials;
    bit          m_gif, m_gdm;
    bit          e_if_rv, e_dm_rv, e_err;
    logic [31:0] e_if_rd, e_dm_rd;
    logic        obs_if_gnt, obs_dm_gnt, obs_en;
    logic [3:0]  obs_be;
    logic [31:0] obs_addr, obs_wdata;
    bit          starve_pat [0:4] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

    always #5 clk_in = ~clk_in;

    unified_mem_arbiter #(.MEM_AW(AW), .STARVE_MAX(SM)) dut (
        .clk_in(clk_in), .rst_in(rst_in),
        .if_req_in(if_req_in), .if_addr_in(if_addr_in), .if_gnt_out(if_gnt_out),
        .if_rvalid_out(if_rvalid_out), .if_rdata_out(if_rdata_out),
        .dm_req_in(dm_req_in), .dm_we_in(dm_we_in), .dm_be_in(dm_be_in),
        .dm_addr_in(dm_addr_in), .dm_wdata_in(dm_wdata_in), .dm_gnt_out(dm_gnt_out),
        .dm_rvalid_out(dm_rvalid_out), .dm_rdata_out(dm_rdata_out), .dm_err_out(dm_err_out),
        .ld_req_in(ld_req_in), .ld_addr_in(ld_addr_in), .ld_wdata_in(ld_wdata_in),
        .ld_done_in(ld_done_in), .ld_gnt_out(ld_gnt_out), .core_stall_out(core_stall_out),
        .mem_en_out(mem_en_out), .mem_we_out(mem_we_out), .mem_be_out(mem_be_out),
        .mem_addr_out(mem_addr_out), .mem_wdata_out(mem_wdata_out), .mem_rdata_in(mem_rdata_in)
    );

    // Synchronous single-port SRAM with byte-lane writes.
    always @(posedge clk_in) begin
        if (mem_en_out) begin
            if (mem_we_out) begin
                for (int b = 0; b < 4; b++)
                    if (mem_be_out[b]) sram[mem_addr_out][8*b +: 8] <= mem_wdata_out[8*b +: 8];
            end else begin
                mem_rdata_in <= sram[mem_addr_out];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] r = $urandom;
        if ($urandom_range(0, 7) == 0) return r | 32'h100;
        return r & 32'hFF;
    endfunction

    // Called just after the negedge once inputs are set; returns at the following negedge.
    task automatic tick();
        bit oor_i, oor_d, g_if, g_dm, g_ld, st;
        int wi, wd, wl;
        chk("if_rvalid", 32'(if_rvalid_out), 32'(e_if_rv));
        chk("if_rdata", if_rdata_out, e_if_rd);
        chk("dm_rvalid", 32'(dm_rvalid_out), 32'(e_dm_rv));
        chk("dm_rdata", dm_rdata_out, e_dm_rd);
        chk("dm_err", 32'(dm_err_out), 32'(e_err));
        #1;
        oor_i = (if_addr_in >> (AW + 2)) != 0;
        oor_d = (dm_addr_in >> (AW + 2)) != 0;
        wi = int'((if_addr_in >> 2) % 64);
        wd = int'((dm_addr_in >> 2) % 64);
        wl = int'((ld_addr_in >> 2) % 64);
        if (!m_run) begin
            g_ld = ld_req_in; g_if = 0; g_dm = 0; st = 1;
        end else begin
            g_ld = 0;
            g_if = if_req_in && (!dm_req_in || denials == SM);
            g_dm = dm_req_in && !g_if;
            st = (if_req_in && !g_if) || (dm_req_in && !g_dm);
        end
        obs_if_gnt = if_gnt_out; obs_dm_gnt = dm_gnt_out; obs_en = mem_en_out;
        obs_be = mem_be_out; obs_addr = 32'(mem_addr_out); obs_wdata = mem_wdata_out;
        chk("if_gnt", 32'(if_gnt_out), 32'(g_if));
        chk("dm_gnt", 32'(dm_gnt_out), 32'(g_dm));
        chk("ld_gnt", 32'(ld_gnt_out), 32'(g_ld));
        chk("stall", 32'(core_stall_out), 32'(st));
        if (g_ld) begin
            chk("ld_en", 32'(mem_en_out), 32'd1);
            chk("ld_we", 32'(mem_we_out), 32'd1);
            chk("ld_be", 32'(mem_be_out), 32'hF);
            chk("ld_addr", 32'(mem_addr_out), 32'(wl));
            chk("ld_wdata", mem_wdata_out, ld_wdata_in);
            ref_mem[wl] = ld_wdata_in;
        end else if (g_if) begin
            chk("if_en", 32'(mem_en_out), 32'(!oor_i));
            if (!oor_i) begin
                chk("if_we", 32'(mem_we_out), 32'd0);
                chk("if_addr", 32'(mem_addr_out), 32'(wi));
            end
        end else if (g_dm) begin
            chk("dm_en", 32'(mem_en_out), 32'(!oor_d));
            if (!oor_d) begin
                chk("dm_we", 32'(mem_we_out), 32'(dm_we_in));
                chk("dm_addr", 32'(mem_addr_out), 32'(wd));
                if (dm_we_in) begin
                    chk("dm_be", 32'(mem_be_out), 32'(dm_be_in));
                    chk("dm_wdata", mem_wdata_out, dm_wdata_in);
                end
            end
        end else begin
            chk("idle_en", 32'(mem_en_out), 32'd0);
        end
        e_if_rv = g_if;
        e_if_rd = (g_if && !oor_i) ? ref_mem[wi] : 32'h0;
        e_dm_rv = g_dm && !dm_we_in;
        e_dm_rd = (g_dm && !dm_we_in && !oor_d) ? ref_mem[wd] : 32'h0;
        e_err   = g_dm && oor_d;
        if (g_dm && dm_we_in && !oor_d)
            for (int b = 0; b < 4; b++)
                if (dm_be_in[b]) ref_mem[wd][8*b +: 8] = dm_wdata_in[8*b +: 8];
        if (m_run && if_req_in && !g_if) denials = (denials < SM) ? denials + 1 : SM;
        else denials = 0;
        if (!m_run && ld_done_in) m_run = 1;
        m_gif = g_if; m_gdm = g_dm;
        @(negedge clk_in);
    endtask

    initial begin
        rst_in = 1; if_req_in = 1; if_addr_in = 0;
        dm_req_in = 0; dm_we_in = 0; dm_be_in = 0; dm_addr_in = 0; dm_wdata_in = 0;
        ld_req_in = 1; ld_addr_in = 0; ld_wdata_in = 0; ld_done_in = 0;
        m_run = 0; denials = 0; e_if_rv = 0; e_dm_rv = 0; e_err = 0; e_if_rd = 0; e_dm_rd = 0;
        @(negedge clk_in); #1;
        chk("rst_ld_gnt", 32'(ld_gnt_out), 32'd0);
        chk("rst_if_gnt", 32'(if_gnt_out), 32'd0);
        chk("rst_stall", 32'(core_stall_out), 32'd1);
        chk("rst_mem_en", 32'(mem_en_out), 32'd0);
        chk("rst_mem_we", 32'(mem_we_out), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr_out), 32'd0);
        chk("rst_if_rvalid", 32'(if_rvalid_out), 32'd0);
        chk("rst_dm_err", 32'(dm_err_out), 32'd0);

        // Boot image: word 0 is fixed, the rest random; done arrives with the last write.
        rst_in = 0; ld_addr_in = 0; ld_wdata_in = 32'h00d60e33;
        tick();
        for (int i = 1; i < 64; i++) begin
            ld_addr_in = 32'(i * 4); ld_wdata_in = $urandom; ld_done_in = (i == 63);
            tick();
        end
        ld_req_in = 0; ld_done_in = 0; if_req_in = 1; if_addr_in = 0;
        tick();
        chk("first_run_if_gnt", 32'(obs_if_gnt), 32'd1);
        chk("boot_fetch_data", if_rdata_out, 32'h00d60e33);
        if_req_in = 0;
        tick();

        // Fetch starvation against back-to-back loads.
        if_req_in = 1; if_addr_in = 32'h4; dm_req_in = 1; dm_we_in = 0; dm_addr_in = 32'h8;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("starve_dm_gnt", 32'(obs_dm_gnt), 32'(starve_pat[k]));
        end
        if_req_in = 0;

        dm_we_in = 1; dm_be_in = 4'b0011; dm_addr_in = 32'h8; dm_wdata_in = 32'hDEADBEEF;
        tick();
        chk("store_addr", obs_addr, 32'd2);
        chk("store_be", 32'(obs_be), 32'h3);
        chk("store_wdata", obs_wdata, 32'hDEADBEEF);
        dm_we_in = 0;
        tick();
        chk("store_no_rvalid_load_gnt", 32'(obs_dm_gnt), 32'd1);

        dm_addr_in = 32'h100;
        tick();
        chk("oor_gnt", 32'(obs_dm_gnt), 32'd1);
        chk("oor_en", 32'(obs_en), 32'd0);
        chk("oor_rvalid", 32'(dm_rvalid_out), 32'd1);
        chk("oor_rdata", dm_rdata_out, 32'h0);
        chk("oor_err", 32'(dm_err_out), 32'd1);
        dm_req_in = 0;
        tick();

        for (int n = 0; n < 400; n++) begin
            if (!if_req_in || m_gif) begin
                if_req_in = ($urandom_range(0, 3) != 0); if_addr_in = rand_addr();
            end
            if (!dm_req_in || m_gdm) begin
                dm_req_in = ($urandom_range(0, 3) != 0); dm_we_in = $urandom_range(0, 1);
                dm_be_in = 4'($urandom); dm_addr_in = rand_addr(); dm_wdata_in = $urandom;
            end
            ld_req_in = $urandom_range(0, 1); ld_done_in = $urandom_range(0, 1);
            ld_addr_in = $urandom; ld_wdata_in = $urandom;
            tick();
        end

        // Reset lands between a fetch grant and its response.
        if_req_in = 1; if_addr_in = 32'h4; dm_req_in = 0; ld_req_in = 0; ld_done_in = 0;
        tick();
        rst_in = 1; #1;
        chk("rstmid_if_rvalid", 32'(if_rvalid_out), 32'd0);
        chk("rstmid_stall", 32'(core_stall_out), 32'd1);
        chk("rstmid_if_gnt", 32'(if_gnt_out), 32'd0);
        chk("rstmid_mem_en", 32'(mem_en_out), 32'd0);
        m_run = 0; denials = 0; e_if_rv = 0; e_dm_rv = 0; e_err = 0; e_if_rd = 0; e_dm_rd = 0;
        @(negedge clk_in);
        chk("rstmid_if_rvalid_late", 32'(if_rvalid_out), 32'd0);
        rst_in = 0; ld_req_in = 1; ld_addr_in = 32'h0; ld_wdata_in = 32'h00d60e33;
        tick();
        ld_req_in = 0; if_req_in = 0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/unified_mem_arbiter.md
# unified_mem_arbiter

Single-port memory arbiter and boot sequencer placed between the RV32I core's instruction-fetch and data ports, a boot-loader write port, and one shared synchronous single-port SRAM. After reset it holds the core in a BOOT phase where only the loader may write program/data images. It then switches to RUN and arbitrates fetch against load/store every cycle, with a starvation bound on fetch. It returns read data one cycle after grant and stalls the core when a requester loses arbitration.

## Interface
- MEM_AW, 6, SRAM word-address width (2^MEM_AW 32-bit words)
- STARVE_MAX, 3, consecutive fetch denials after which fetch wins over data
- clk_in  in  1  clock, rising edge
- rst_in  in  1  reset, asynchronous, active-high
- if_req_in / if_addr_in  in  1 / 32  fetch request, byte address
- if_gnt_out  out  1  fetch granted this cycle
- if_rvalid_out / if_rdata_out  out  1 / 32  fetch data, one cycle after grant
- dm_req_in / dm_we_in  in  1 / 1  data request; 1 = store
- dm_be_in  in  4  store byte enables
- dm_addr_in / dm_wdata_in  in  32 / 32  data byte address, store data
- dm_gnt_out  out  1  data request granted this cycle
- dm_rvalid_out / dm_rdata_out  out  1 / 32  load data, one cycle after grant; loads only
- dm_err_out  out  1  out-of-range data access; aligned with dm_rvalid_out or, for stores, the cycle after grant
- ld_req_in / ld_addr_in / ld_wdata_in  in  1 / 32 / 32  loader full-word write
- ld_done_in  in  1  loader finished; one-cycle pulse
- ld_gnt_out  out  1  loader write accepted
- core_stall_out  out  1  core must hold its requests
- mem_en_out / mem_we_out  out  1 / 1  SRAM enable, write
- mem_be_out  out  4  SRAM byte enables
- mem_addr_out / mem_wdata_out  out  MEM_AW / 32  SRAM word address, write data
- mem_rdata_in  in  32  SRAM read data, valid one cycle after a read enable

## Operation
- States: BOOT and RUN. Reset enters BOOT. BOOT moves to RUN on the clock edge where ld_done_in=1. RUN stays in RUN until reset.
- BOOT:
  - ld_gnt_out = ld_req_in. Write-only, with mem_be_out=4'hF.
  - if_gnt_out=0, dm_gnt_out=0, core_stall_out=1.
  - If ld_req_in and ld_done_in are high in the same cycle, the write is performed, then the block moves to RUN.
- RUN:
  - ld_req_in and ld_done_in are ignored; ld_gnt_out=0.
  - Priority is data over fetch, except when starve_cnt == STARVE_MAX. In that case fetch wins.
  - Grant is combinational in the request cycle, and the mem_* outputs are driven that same cycle.
  - core_stall_out = (if_req_in & ~if_gnt_out) | (dm_req_in & ~dm_gnt_out).
- starve_cnt:
  - Increments (saturating at STARVE_MAX) each RUN cycle with if_req_in & ~if_gnt_out.
  - Clears on if_gnt_out, or when if_req_in=0.
- Address mapping: word address = addr[MEM_AW+1:2], and addr[1:0] is ignored.
- Out of range means addr[31:MEM_AW+2] != 0:
  - Granted normally, but mem_en_out=0.
  - A load returns rdata 0.
  - A store is dropped.
  - dm_err_out pulses. Fetch out-of-range returns 0 with no error.
- Response owner: a registered tag (NONE/IF/DM) records which port issued the read.
  - *_rvalid_out is high for the owning port in the next cycle.
  - *_rdata_out = rvalid ? mem_rdata_in (or 0 if out of range) : 0.
- Stores and loader writes produce no rvalid.

## Timing
- Reset values:
  - State BOOT; starve_cnt 0; owner tag NONE.
  - All grants, rvalids, rdata, and dm_err_out are 0.
  - All mem_* outputs are 0.
  - core_stall_out is 1.
  - While rst_in is high, all grants and mem_en_out are forced to 0.
- Read latency: grant in cycle N, rvalid/rdata in cycle N+1. Back-to-back grants every cycle are allowed.
- Reset asserted between grant and response: the response is dropped (rvalid stays 0), and the block restarts in BOOT.
- At most one of if_gnt_out, dm_gnt_out, ld_gnt_out is high in any cycle.
- Requesters hold their request and address stable until granted.

## Structure
- Shared package holds:
  - the state enum (ST_BOOT, ST_RUN);
  - the owner enum (OWN_NONE, OWN_IF, OWN_DM);
  - the full-word byte-enable constant BE_ALL=4'hF.
- Single module, no sub-module. The starvation counter and priority pick are small enough to stay inline.

## Test plan
- Boot write: reset, then ld_req_in=1, ld_addr_in=0x0, ld_wdata_in=0x00d60e33, with if_req_in=1.
  - Response: ld_gnt_out=1, mem_we_out=1, mem_addr_out=0, mem_be_out=4'hF, if_gnt_out=0, core_stall_out=1.
- Boot exit and fetch: ld_done_in pulse, then if_req_in=1, if_addr_in=0x0.
  - Response: if_gnt_out=1 in the first RUN cycle; next cycle if_rvalid_out=1 and if_rdata_out=0x00d60e33.
- Starvation: continuous if_req_in with dm load to 0x8 every cycle, STARVE_MAX=3.
  - Response: dm_gnt_out for 3 cycles, if_gnt_out on the 4th, starve_cnt back to 0, then dm wins again.
- Byte store: dm_we_in=1, dm_be_in=4'b0011, dm_addr_in=0x8, dm_wdata_in=0xDEADBEEF.
  - Response: mem_addr_out=2, mem_be_out=4'b0011, mem_wdata_out=0xDEADBEEF, no dm_rvalid_out.
- Out of range: dm load at 0x100 with MEM_AW=6.
  - Response: dm_gnt_out=1, mem_en_out=0; next cycle dm_rvalid_out=1, dm_rdata_out=0, dm_err_out=1.
- Reset mid-read: rst_in asserted the cycle after a fetch grant.
  - Response: if_rvalid_out stays 0, core_stall_out=1, state BOOT, ld_gnt_out follows ld_req_in after reset release.
